// File: rtl/wt_store_coalesce_buffer_pkg.sv
// Shared types for the write-through store coalescing buffer (package wt_store_buf_pkg).
// Optional store merging is compiled in with WBUF_COALESCE_EN.
package wt_store_buf_pkg;

    localparam int unsigned WBUF_XLEN = 32;
    localparam int unsigned WBUF_PLEN = 34;
    localparam int unsigned WBUF_BE_W = WBUF_XLEN / 8;

    typedef struct packed {
        logic [WBUF_PLEN-1:0] addr;
        logic [WBUF_XLEN-1:0] data;
        logic [WBUF_BE_W-1:0] be;
        logic                 nc;
        logic                 valid;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } flush_state_e;

endpackage

// File: rtl/wt_store_coalesce_buffer_byte_merge.sv
// Per-byte merge of a store into an existing entry image: enabled bytes of the
// new store overwrite, byte enables accumulate.
module wbuf_byte_merge #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]   old_data_i,
    input  logic [XLEN/8-1:0] old_be_i,
    input  logic [XLEN-1:0]   new_data_i,
    input  logic [XLEN/8-1:0] new_be_i,
    output logic [XLEN-1:0]   merged_data_o,
    output logic [XLEN/8-1:0] merged_be_o
);

    // byte-lane select between the stored image and the incoming store
    always_comb begin
        merged_data_o = old_data_i;
        for (int b = 0; b < XLEN / 8; b++) begin
            if (new_be_i[b]) begin
                merged_data_o[8*b +: 8] = new_data_i[8*b +: 8];
            end else begin
                merged_data_o[8*b +: 8] = old_data_i[8*b +: 8];
            end
        end
        merged_be_o = old_be_i | new_be_i;
    end

endmodule

// File: rtl/wt_store_coalesce_buffer.sv
// Write-through store buffer: in-order FIFO with optional same-word merging of
// the youngest cacheable entry (WBUF_COALESCE_EN), load-hit check and flush.
module wt_store_coalesce_buffer
    import wt_store_buf_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PLEN  = 34,
    parameter int unsigned DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              st_valid_i,
    output logic              st_ready_o,
    input  logic [PLEN-1:0]   st_addr_i,
    input  logic [XLEN-1:0]   st_data_i,
    input  logic [XLEN/8-1:0] st_be_i,
    input  logic              st_nc_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [PLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_data_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic              mem_nc_o,
    input  logic [PLEN-1:0]   ld_addr_i,
    output logic              ld_hit_o,
    input  logic              flush_i,
    output logic              flush_done_o,
    output logic              empty_o
);

    localparam int unsigned BEW = XLEN / 8;
    localparam int unsigned OFF = $clog2(BEW);
    localparam int unsigned WAW = PLEN - OFF;
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;

    logic [WAW-1:0]   addr_q [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [BEW-1:0]   be_q   [DEPTH];
    logic [DEPTH-1:0] nc_q;
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q, count_d;
    flush_state_e     state_q;
    logic             flush_done_q;

    logic [WAW-1:0]   st_word_s, ld_word_s;
    logic             unused_low_s;
    logic             not_empty_s, full_s;
    logic             push_s, pop_s, alloc_s;
    logic             coal_ok_s, coalesce_s;
    logic [XLEN-1:0]  old_data_s, merged_data_s;
    logic [BEW-1:0]   old_be_s, merged_be_s;
    logic             ld_hit_s;

    assign st_word_s    = st_addr_i[PLEN-1:OFF];
    assign ld_word_s    = ld_addr_i[PLEN-1:OFF];
    assign unused_low_s = ^{st_addr_i[OFF-1:0], ld_addr_i[OFF-1:0]};
    assign not_empty_s  = (count_q != CW'(0));
    assign full_s       = (count_q == CW'(DEPTH));
    assign pop_s        = not_empty_s & mem_ready_i;

`ifdef WBUF_COALESCE_EN
    logic [PW-1:0] young_s;
    assign young_s    = tail_q - PW'(1);
    assign coal_ok_s  = not_empty_s & valid_q[young_s] & ~nc_q[young_s] & ~st_nc_i
                      & (addr_q[young_s] == st_word_s);
    // a lone entry leaving this cycle cannot absorb the store; it allocates instead
    assign coalesce_s = coal_ok_s & ~((count_q == CW'(1)) & pop_s);
    assign old_data_s = coalesce_s ? data_q[young_s] : '0;
    assign old_be_s   = coalesce_s ? be_q[young_s]   : '0;
`else
    assign coal_ok_s  = 1'b0;
    assign coalesce_s = 1'b0;
    assign old_data_s = '0;
    assign old_be_s   = '0;
`endif

    assign st_ready_o = (state_q == IDLE) & (~full_s | coal_ok_s);
    assign push_s     = st_valid_i & st_ready_o;
    assign alloc_s    = push_s & ~coalesce_s;

    wbuf_byte_merge #(
        .XLEN (XLEN)
    ) u_merge (
        .old_data_i    (old_data_s),
        .old_be_i      (old_be_s),
        .new_data_i    (st_data_i),
        .new_be_i      (st_be_i),
        .merged_data_o (merged_data_s),
        .merged_be_o   (merged_be_s)
    );

    // next occupancy from allocate/pop combination
    always_comb begin
        case ({alloc_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // entry storage: allocate at tail, merge into youngest, invalidate on pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
            nc_q    <= '0;
            valid_q <= '0;
        end else begin
            if (pop_s) begin
                valid_q[head_q] <= 1'b0;
            end
            if (alloc_s) begin
                addr_q[tail_q]  <= st_word_s;
                data_q[tail_q]  <= merged_data_s;
                be_q[tail_q]    <= merged_be_s;
                nc_q[tail_q]    <= st_nc_i;
                valid_q[tail_q] <= 1'b1;
            end
`ifdef WBUF_COALESCE_EN
            else if (push_s && coalesce_s) begin
                data_q[young_s] <= merged_data_s;
                be_q[young_s]   <= merged_be_s;
            end
`endif
        end
    end

    // circular pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop_s) begin
                head_q <= head_q + PW'(1);
            end
            if (alloc_s) begin
                tail_q <= tail_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // flush sequencing with registered completion pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= (state_q == DRAIN) && !not_empty_s;
            case (state_q)
                IDLE:    state_q <= flush_i ? DRAIN : IDLE;
                DRAIN:   state_q <= not_empty_s ? DRAIN : DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // word-address match against every live entry
    always_comb begin
        ld_hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_hit_s = ld_hit_s | (valid_q[i] & (addr_q[i] == ld_word_s));
        end
    end

    assign mem_valid_o  = not_empty_s;
    assign mem_addr_o   = not_empty_s ? {addr_q[head_q], {OFF{1'b0}}} : '0;
    assign mem_data_o   = not_empty_s ? data_q[head_q] : '0;
    assign mem_be_o     = not_empty_s ? be_q[head_q] : '0;
    assign mem_nc_o     = not_empty_s & nc_q[head_q];
    assign ld_hit_o     = ld_hit_s;
    assign flush_done_o = flush_done_q;
    assign empty_o      = ~not_empty_s;

endmodule

// File: tb/tb_wt_store_coalesce_buffer.sv
// Scoreboard bench for wt_store_coalesce_buffer; expectations follow WBUF_COALESCE_EN.
module tb_wt_store_coalesce_buffer;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [33:0] st_addr = 34'h0;
    logic [31:0] st_data = 32'h0;
    logic [3:0]  st_be = 4'h0;
    logic        st_nc = 1'b0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [33:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;
    logic        mem_nc;
    logic [33:0] ld_addr = 34'h0;
    logic        ld_hit;
    logic        flush = 1'b0;
    logic        flush_done;
    logic        empty;

    typedef struct packed {
        logic [33:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        nc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_at;

    wt_store_coalesce_buffer #(.XLEN(32), .PLEN(34), .DEPTH(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .st_valid_i   (st_valid),
        .st_ready_o   (st_ready),
        .st_addr_i    (st_addr),
        .st_data_i    (st_data),
        .st_be_i      (st_be),
        .st_nc_i      (st_nc),
        .mem_valid_o  (mem_valid),
        .mem_ready_i  (mem_ready),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_data),
        .mem_be_o     (mem_be),
        .mem_nc_o     (mem_nc),
        .ld_addr_i    (ld_addr),
        .ld_hit_o     (ld_hit),
        .flush_i      (flush),
        .flush_done_o (flush_done),
        .empty_o      (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // monitor: every accepted head entry is compared against the oldest expectation
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        if (rst_ni && mem_valid && mem_ready) begin
            got = '{mem_addr, mem_data, mem_be, mem_nc};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got addr=0x%0h data=0x%0h be=0x%0h nc=%0b required no entry",
                         got.addr, got.data, got.be, got.nc);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL pop: got addr=0x%0h data=0x%0h be=0x%0h nc=%0b required addr=0x%0h data=0x%0h be=0x%0h nc=%0b",
                             got.addr, got.data, got.be, got.nc, want.addr, want.data, want.be, want.nc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [33:0] a, input logic [31:0] d, input logic [3:0] be, input logic nc);
        exp_q.push_back('{a, d, be, nc});
    endtask

    task automatic store(input logic [33:0] a, input logic [31:0] d, input logic [3:0] be, input logic nc);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = be;
        st_nc    = nc;
        #1;
        chk("store_ready", st_ready, 1);
        tick();
        st_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        mem_ready = 1'b1;
        while (!empty && n < 40) begin
            tick();
            n++;
        end
        chk(name, empty, 1);
        mem_ready = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_st_ready", st_ready, 1);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_ld_hit", ld_hit, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_empty", empty, 1);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        tick();

        // single full-word store, one cycle to presentation
        expect_entry(34'h100, 32'hAABBCCDD, 4'hF, 1'b0);
        store(34'h100, 32'hAABBCCDD, 4'hF, 1'b0);
        chk("t1_mem_valid", mem_valid, 1);
        chk("t1_mem_addr", mem_addr, 34'h100);
        chk("t1_mem_be", mem_be, 4'hF);
        drain("t1_empty");

        // back-to-back cacheable stores to the same word
        store(34'h100, 32'h00000011, 4'h1, 1'b0);
        store(34'h101, 32'h00002200, 4'h2, 1'b0);
`ifdef WBUF_COALESCE_EN
        expect_entry(34'h100, 32'h00002211, 4'h3, 1'b0);
        chk("t2_data_low", mem_data[15:0], 16'h2211);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("t2_single_entry", empty, 1);
`else
        expect_entry(34'h100, 32'h00000011, 4'h1, 1'b0);
        expect_entry(34'h100, 32'h00002200, 4'h2, 1'b0);
        drain("t2_empty");
`endif

        // non-cacheable stores never merge
        expect_entry(34'h100, 32'h00000011, 4'h1, 1'b1);
        expect_entry(34'h100, 32'h00002200, 4'h2, 1'b1);
        store(34'h100, 32'h00000011, 4'h1, 1'b1);
        store(34'h101, 32'h00002200, 4'h2, 1'b1);
        chk("t3_nc", mem_nc, 1);
        drain("t3_empty");

        // fill to full, then probe readiness
        for (int i = 0; i < 8; i++) begin
            store(34'h1000 + 34'(4 * i), 32'(i), 4'hF, 1'b0);
        end
        for (int i = 0; i < 7; i++) begin
            expect_entry(34'h1000 + 34'(4 * i), 32'(i), 4'hF, 1'b0);
        end
        st_addr = 34'h2000;
        #1;
        chk("t4_full_new", st_ready, 0);
        st_addr = 34'h101C;
        #1;
`ifdef WBUF_COALESCE_EN
        chk("t4_full_match", st_ready, 1);
        st_data  = 32'h000000AA;
        st_be    = 4'h1;
        st_valid = 1'b1;
        tick();
        st_valid = 1'b0;
        expect_entry(34'h101C, 32'h000000AA, 4'hF, 1'b0);
`else
        chk("t4_full_match", st_ready, 0);
        expect_entry(34'h101C, 32'h00000007, 4'hF, 1'b0);
`endif
        mem_ready = 1'b1;
        tick();
        expect_entry(34'h2000, 32'h00000020, 4'hF, 1'b0);
        store(34'h2000, 32'h00000020, 4'hF, 1'b0);
        mem_ready = 1'b0;
        expect_entry(34'h2004, 32'h00000024, 4'hF, 1'b0);
        store(34'h2004, 32'h00000024, 4'hF, 1'b0);
        st_addr = 34'h3000;
        #1;
        chk("t4_full_again", st_ready, 0);
        drain("t4_empty");

        // load conflict detection
        expect_entry(34'h200, 32'h1, 4'hF, 1'b0);
        expect_entry(34'h300, 32'h2, 4'hF, 1'b0);
        store(34'h200, 32'h1, 4'hF, 1'b0);
        store(34'h300, 32'h2, 4'hF, 1'b0);
        ld_addr = 34'h302;
        #1;
        chk("t5_hit_302", ld_hit, 1);
        ld_addr = 34'h400;
        #1;
        chk("t5_miss_400", ld_hit, 0);
        ld_addr = 34'h200;
        #1;
        chk("t5_hit_200", ld_hit, 1);
        ld_addr = 34'h0;
        drain("t5_empty");
        #1;
        chk("t5_hit_after_drain", ld_hit, 0);

        // flush with three entries pending
        for (int i = 0; i < 3; i++) begin
            expect_entry(34'h500 + 34'(4 * i), 32'(i + 5), 4'hF, 1'b0);
            store(34'h500 + 34'(4 * i), 32'(i + 5), 4'hF, 1'b0);
        end
        flush = 1'b1;
        mem_ready = 1'b1;
        done_at = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) begin
                st_valid = 1'b1;
                st_addr  = 34'h600;
                st_be    = 4'hF;
                st_data  = 32'h66;
                #1;
                chk("t6_blocked", st_ready, 0);
            end
            if (flush_done) begin
                done_at = k;
                break;
            end
        end
        st_valid = 1'b0;
        flush = 1'b0;
        chk("t6_done_cycle", done_at, 4);
        chk("t6_empty", empty, 1);
        tick();
        mem_ready = 1'b0;
        chk("t6_done_pulse_end", flush_done, 0);
        chk("t6_ready_back", st_ready, 1);

        // reset during drain discards everything
        store(34'h700, 32'h7, 4'hF, 1'b0);
        store(34'h704, 32'h8, 4'hF, 1'b0);
        flush = 1'b1;
        tick();
        rst_ni = 1'b0;
        flush = 1'b0;
        #1;
        chk("t7_rst_empty", empty, 1);
        chk("t7_rst_mem_valid", mem_valid, 0);
        chk("t7_rst_ready", st_ready, 1);
        tick();
        rst_ni = 1'b1;
        tick();
        expect_entry(34'h800, 32'h9, 4'hF, 1'b0);
        store(34'h800, 32'h9, 4'hF, 1'b0);
        drain("t7_empty");

        chk("leftover_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
